// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter unit with registered Z/N flags, a memory-indirect
// jump wait state and a programmable squash (flush) window after each redirect.
// Optional feature macro: PC_LINK_REG_EN adds a link_pc return-address register.
module pc_sequencer #(
  parameter int unsigned    AW          = 32,
  parameter int unsigned    FLUSH_DEPTH = 2,
  parameter logic [AW-1:0]  RESET_PC    = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic [1:0]    pc_sel,
  input  logic          br_z,
  input  logic          br_n,
  input  logic          alu_z,
  input  logic          alu_n,
  input  logic          flag_we,
  input  logic [AW-1:0] rs_val,
  input  logic [AW-1:0] jmp_target,
  input  logic [AW-1:0] mem_target,
  input  logic          mem_target_valid,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] pc_plus1,
  output logic          z_flag,
  output logic          n_flag,
  output logic          redirect,
  output logic          flush,
  output logic          wait_mem
`ifdef PC_LINK_REG_EN
  ,
  output logic [AW-1:0] link_pc
`endif
);

  typedef enum logic {S_RUN = 1'b0, S_MEM_WAIT = 1'b1} state_e;

  // Counter is 4 bits wide: FLUSH_DEPTH is limited to 0..15.
  localparam logic [3:0] FD = 4'(FLUSH_DEPTH);

  state_e        state_q;
  logic [AW-1:0] pc_q;
  logic          z_q, n_q;
  logic          redirect_q;
  logic          wait_q;
  logic [3:0]    cnt_q;
  logic          taken;
`ifdef PC_LINK_REG_EN
  logic [AW-1:0] link_q;
`endif

  // Incrementer wraps naturally at AW bits.
  assign pc_plus1 = pc_q + {{(AW-1){1'b0}}, 1'b1};

  // Branch decision uses the registered flags only (no bypass from flag_we).
  assign taken = (br_z & z_q) | (br_n & n_q);

  // PC / flag / FSM state; all outputs registered except pc_plus1 and flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_RUN;
      pc_q       <= RESET_PC;
      z_q        <= 1'b0;
      n_q        <= 1'b0;
      redirect_q <= 1'b0;
      wait_q     <= 1'b0;
      cnt_q      <= 4'd0;
`ifdef PC_LINK_REG_EN
      link_q     <= '0;
`endif
    end else begin
      redirect_q <= 1'b0;
      // Flags update independently of state and stall.
      if (flag_we) begin
        z_q <= alu_z;
        n_q <= alu_n;
      end
      case (state_q)
        S_RUN: begin
          if (!stall) begin
            if (cnt_q != 4'd0) begin
              // Squashed slot: decoder request is ignored, fetch keeps streaming.
              pc_q  <= pc_plus1;
              cnt_q <= cnt_q - 4'd1;
            end else begin
              case (pc_sel)
                2'b00: pc_q <= pc_plus1;
                2'b01: begin
                  if (taken) begin
                    pc_q       <= rs_val;
                    redirect_q <= 1'b1;
                    cnt_q      <= FD;
                  end else begin
                    pc_q <= pc_plus1;
                  end
                end
                2'b10: begin
                  pc_q       <= jmp_target;
                  redirect_q <= 1'b1;
                  cnt_q      <= FD;
`ifdef PC_LINK_REG_EN
                  link_q     <= pc_plus1;
`endif
                end
                default: begin
                  // Memory-indirect jump: hold pc until the target arrives.
                  state_q <= S_MEM_WAIT;
                  wait_q  <= 1'b1;
`ifdef PC_LINK_REG_EN
                  link_q  <= pc_plus1;
`endif
                end
              endcase
            end
          end
        end
        S_MEM_WAIT: begin
          // Stall is deliberately ignored here; the fill completes regardless.
          if (mem_target_valid) begin
            pc_q       <= mem_target;
            redirect_q <= 1'b1;
            cnt_q      <= FD;
            state_q    <= S_RUN;
            wait_q     <= 1'b0;
          end
        end
        default: begin
          state_q <= S_RUN;
          wait_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pc       = pc_q;
  assign z_flag   = z_q;
  assign n_flag   = n_q;
  assign redirect = redirect_q;
  assign wait_mem = wait_q;
  assign flush    = (cnt_q != 4'd0) | wait_q;
`ifdef PC_LINK_REG_EN
  assign link_pc  = link_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (AW=8, RESET_PC=0x10, FLUSH_DEPTH=2).
module tb_pc_sequencer;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset, stall, br_z, br_n, alu_z, alu_n, flag_we, mem_target_valid;
  logic [1:0]    pc_sel;
  logic [AW-1:0] rs_val, jmp_target, mem_target;
  logic [AW-1:0] pc, pc_plus1;
  logic          z_flag, n_flag, redirect, flush, wait_mem;
`ifdef PC_LINK_REG_EN
  logic [AW-1:0] link_pc;
`endif

  int tests = 0;
  int failed = 0;

  pc_sequencer #(.AW(AW), .FLUSH_DEPTH(2), .RESET_PC(8'h10)) dut (
    .clk(clk), .reset(reset), .stall(stall), .pc_sel(pc_sel), .br_z(br_z), .br_n(br_n),
    .alu_z(alu_z), .alu_n(alu_n), .flag_we(flag_we), .rs_val(rs_val),
    .jmp_target(jmp_target), .mem_target(mem_target), .mem_target_valid(mem_target_valid),
    .pc(pc), .pc_plus1(pc_plus1), .z_flag(z_flag), .n_flag(n_flag),
    .redirect(redirect), .flush(flush), .wait_mem(wait_mem)
`ifdef PC_LINK_REG_EN
    , .link_pc(link_pc)
`endif
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; pc_sel = 2'b00; br_z = 1'b0; br_n = 1'b0;
    alu_z = 1'b0; alu_n = 1'b0; flag_we = 1'b0; mem_target_valid = 1'b0;
    rs_val = '0; jmp_target = '0; mem_target = '0;
    step(); step();
    tests++; if (pc !== 8'h10) begin failed++; $display("FAIL reset_pc got=%h exp=10", pc); end
    tests++; if (pc_plus1 !== 8'h11) begin failed++; $display("FAIL reset_pc_plus1 got=%h exp=11", pc_plus1); end
    tests++; if ({z_flag, n_flag, redirect, flush, wait_mem} !== 5'b0) begin
      failed++; $display("FAIL reset_ctl got=%b exp=00000", {z_flag, n_flag, redirect, flush, wait_mem}); end
  endtask

  task automatic test_sequential();
    logic [AW-1:0] exp_pc;
    reset = 1'b0;
    exp_pc = 8'h10;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_pc = exp_pc + 8'h01;
      tests++; if (pc !== exp_pc) begin failed++; $display("FAIL seq_pc%0d got=%h exp=%h", i, pc, exp_pc); end
      tests++; if ({redirect, flush} !== 2'b00) begin failed++; $display("FAIL seq_ctl%0d got=%b exp=00", i, {redirect, flush}); end
    end
  endtask

  task automatic test_branch_taken();
    flag_we = 1'b1; alu_z = 1'b1; pc_sel = 2'b00;
    step();  // pc 0x14, z=1
    tests++; if ({pc, z_flag} !== {8'h14, 1'b1}) begin failed++; $display("FAIL flag_set got=%h/%b exp=14/1", pc, z_flag); end
    flag_we = 1'b0; pc_sel = 2'b01; br_z = 1'b1; rs_val = 8'h40;
    step();
    tests++; if ({pc, redirect, flush} !== {8'h40, 2'b11}) begin
      failed++; $display("FAIL br_taken got=%h/%b%b exp=40/11", pc, redirect, flush); end
    pc_sel = 2'b10; jmp_target = 8'h99; br_z = 1'b0;
    step();
    tests++; if ({pc, redirect, flush} !== {8'h41, 2'b01}) begin
      failed++; $display("FAIL squash1 got=%h/%b%b exp=41/01", pc, redirect, flush); end
    step();
    tests++; if ({pc, redirect, flush} !== {8'h42, 2'b00}) begin
      failed++; $display("FAIL squash2 got=%h/%b%b exp=42/00", pc, redirect, flush); end
    pc_sel = 2'b00;
    step();
    tests++; if (pc !== 8'h43) begin failed++; $display("FAIL post_squash got=%h exp=43", pc); end
  endtask

  task automatic test_branch_no_bypass();
    flag_we = 1'b1; alu_z = 1'b0; alu_n = 1'b0; pc_sel = 2'b00;
    step();  // pc 0x44, flags cleared
    alu_z = 1'b1; pc_sel = 2'b01; br_z = 1'b1; rs_val = 8'h70;
    step();
    tests++; if ({pc, redirect, z_flag} !== {8'h45, 1'b0, 1'b1}) begin
      failed++; $display("FAIL no_bypass got=%h/%b/%b exp=45/0/1", pc, redirect, z_flag); end
    flag_we = 1'b0; br_z = 1'b0; br_n = 1'b1;
    step();  // n_flag=0 -> not taken even though z_flag=1
    tests++; if ({pc, redirect} !== {8'h46, 1'b0}) begin
      failed++; $display("FAIL br_n_not_taken got=%h/%b exp=46/0", pc, redirect); end
    br_n = 1'b0; pc_sel = 2'b00;
  endtask

  task automatic test_mem_jump();
    pc_sel = 2'b10; jmp_target = 8'h1E;
    step();
    pc_sel = 2'b00;
    step(); step();
    tests++; if ({pc, flush} !== {8'h20, 1'b0}) begin failed++; $display("FAIL mem_setup got=%h/%b exp=20/0", pc, flush); end
    pc_sel = 2'b11;
    step();
    tests++; if ({pc, wait_mem, flush, redirect} !== {8'h20, 3'b110}) begin
      failed++; $display("FAIL mem_enter got=%h/%b%b%b exp=20/110", pc, wait_mem, flush, redirect); end
    pc_sel = 2'b10; jmp_target = 8'h55;
    for (int i = 0; i < 3; i++) begin
      stall = (i == 1);
      step();
      tests++; if ({pc, wait_mem, flush} !== {8'h20, 2'b11}) begin
        failed++; $display("FAIL mem_hold%0d got=%h/%b%b exp=20/11", i, pc, wait_mem, flush); end
    end
    stall = 1'b1; mem_target_valid = 1'b1; mem_target = 8'h80; pc_sel = 2'b00;
    step();  // stall ignored in MEM_WAIT
    tests++; if ({pc, redirect, wait_mem, flush} !== {8'h80, 3'b101}) begin
      failed++; $display("FAIL mem_fill got=%h/%b%b%b exp=80/101", pc, redirect, wait_mem, flush); end
`ifdef PC_LINK_REG_EN
    tests++; if (link_pc !== 8'h21) begin failed++; $display("FAIL link_pc got=%h exp=21", link_pc); end
`endif
    stall = 1'b0; mem_target_valid = 1'b0;
    step(); step();
    tests++; if ({pc, redirect, flush} !== {8'h82, 2'b00}) begin
      failed++; $display("FAIL mem_drain got=%h/%b%b exp=82/00", pc, redirect, flush); end
  endtask

  task automatic test_wrap_and_stall();
    pc_sel = 2'b10; jmp_target = 8'hFD;
    step();
    pc_sel = 2'b00;
    step(); step();
    tests++; if ({pc, pc_plus1} !== {8'hFF, 8'h00}) begin
      failed++; $display("FAIL wrap_pre got=%h/%h exp=ff/00", pc, pc_plus1); end
    step();
    tests++; if ({pc, redirect} !== {8'h00, 1'b0}) begin failed++; $display("FAIL wrap got=%h/%b exp=00/0", pc, redirect); end
    stall = 1'b1; pc_sel = 2'b10; jmp_target = 8'h55;
    step();
    tests++; if ({pc, redirect} !== {8'h00, 1'b0}) begin failed++; $display("FAIL stall_jump got=%h/%b exp=00/0", pc, redirect); end
    stall = 1'b0; jmp_target = 8'h30;
    step();
    stall = 1'b1; pc_sel = 2'b00;
    step(); step();  // counter frozen while stalled
    tests++; if ({pc, redirect, flush} !== {8'h30, 2'b01}) begin
      failed++; $display("FAIL stall_flush got=%h/%b%b exp=30/01", pc, redirect, flush); end
    stall = 1'b0;
    step();
    tests++; if ({pc, flush} !== {8'h31, 1'b1}) begin failed++; $display("FAIL unstall1 got=%h/%b exp=31/1", pc, flush); end
    step();
    tests++; if ({pc, flush} !== {8'h32, 1'b0}) begin failed++; $display("FAIL unstall2 got=%h/%b exp=32/0", pc, flush); end
  endtask

  task automatic test_reset_in_mem_wait();
    flag_we = 1'b1; alu_z = 1'b1; alu_n = 1'b1; pc_sel = 2'b11;
    step();
    tests++; if ({wait_mem, z_flag, n_flag} !== 3'b111) begin
      failed++; $display("FAIL rst_setup got=%b exp=111", {wait_mem, z_flag, n_flag}); end
    flag_we = 1'b0; pc_sel = 2'b00; reset = 1'b1;
    step();
    tests++; if ({pc, wait_mem, flush, z_flag, n_flag, redirect} !== {8'h10, 5'b0}) begin
      failed++; $display("FAIL rst_mem_wait got=%h/%b exp=10/00000", pc, {wait_mem, flush, z_flag, n_flag, redirect}); end
    reset = 1'b0;
    step();
    tests++; if ({pc, wait_mem} !== {8'h11, 1'b0}) begin failed++; $display("FAIL rst_resume got=%h/%b exp=11/0", pc, wait_mem); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch_taken();
    test_branch_no_bypass();
    test_mem_jump();
    test_wrap_and_stall();
    test_reset_in_mem_wait();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
